// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter and its bus analyser decoder.
package serial_frame_tx_pkg;

    // Frame layout: START, CMD (LSB first), ADDR (LSB first), EOF
    localparam int CMD_W      = 8;
    localparam int ADDR_W     = 4;
    localparam int EOF_W      = 2;
    localparam int FRAME_BITS = 1 + CMD_W + ADDR_W + EOF_W;
    localparam int REQ_W      = CMD_W + ADDR_W;
    localparam int LEVEL_W    = 5;

    localparam logic START_LVL = 1'b0;
    localparam logic EOF_LVL   = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StCmd,
        StAddr,
        StEof,
        StGap
    } tx_state_e;

    // Queue entries are {cmd, addr}; the shifter wants addr above cmd so bits leave LSB first.
    function automatic logic [REQ_W-1:0] frame_order(input logic [REQ_W-1:0] cmd_addr);
        return {cmd_addr[ADDR_W-1:0], cmd_addr[REQ_W-1:ADDR_W]};
    endfunction

endpackage

// File: rtl/sft_fifo.sv
// Request queue: power-of-two deep FIFO with level count and same-edge push/pop.
module sft_fifo
    import serial_frame_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [WIDTH-1:0]   i_data,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [LEVEL_W-1:0] o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_level == LEVEL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    // A pop frees the slot a simultaneous push lands in, so writing at full is safe then.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer and level bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_level <= r_level + 5'd1;
            else if (!w_do_push && w_do_pop) r_level <= r_level - 5'd1;
        end
    end

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: queues {cmd, addr} requests and shifts them out as framed bits.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int unsigned DIV      = 1,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned GAP_BITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [CMD_W-1:0]   i_req_cmd,
    input  logic [ADDR_W-1:0]  i_req_addr,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_frame_done,
    output logic [LEVEL_W-1:0] o_q_level
);

    localparam logic [7:0] BIT_RELOAD = 8'(DIV - 1);
    localparam logic [3:0] CMD_LAST   = 4'(CMD_W - 1);
    localparam logic [3:0] ADDR_LAST  = 4'(ADDR_W - 1);
    localparam logic [3:0] EOF_LAST   = 4'(EOF_W - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_BITS - 1);

    tx_state_e        r_state, w_state_d;
    logic             r_tx, w_tx_d;
    logic             r_done, w_done_d;
    logic [7:0]       r_timer, w_timer_d;
    logic [3:0]       r_cnt, w_cnt_d;
    logic [REQ_W-1:0] r_shift, w_shift_d;
    logic             w_tick;
    logic             w_launch;
    logic             w_full;
    logic             w_empty;
    logic [REQ_W-1:0] w_head;

    sft_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_req_valid && o_req_ready),
        .i_pop   (w_launch),
        .i_data  ({i_req_cmd, i_req_addr}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_q_level)
    );

    assign o_req_ready  = !w_full;
    assign o_tx         = r_tx;
    assign o_busy       = (r_state != StIdle);
    assign o_frame_done = r_done;
    assign w_tick       = (r_timer == 8'd0);

    // State, line, bit-timer, field counter and shifter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
            r_tx    <= IDLE_LVL;
            r_done  <= 1'b0;
            r_timer <= 8'd0;
            r_cnt   <= 4'd0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_d;
            r_tx    <= w_tx_d;
            r_done  <= w_done_d;
            r_timer <= w_timer_d;
            r_cnt   <= w_cnt_d;
            r_shift <= w_shift_d;
        end
    end

    // Next-state: advance one bit per timer expiry, launch a new frame from IDLE or GAP end.
    always_comb begin
        w_state_d = r_state;
        w_tx_d    = r_tx;
        w_done_d  = 1'b0;
        w_timer_d = w_tick ? r_timer : r_timer - 8'd1;
        w_cnt_d   = r_cnt;
        w_shift_d = r_shift;
        w_launch  = 1'b0;
        unique case (r_state)
            StIdle: w_launch = !w_empty;
            StStart: begin
                if (w_tick) begin
                    w_state_d = StCmd;
                    w_tx_d    = r_shift[0];
                    w_timer_d = BIT_RELOAD;
                    w_cnt_d   = 4'd0;
                end
            end
            StCmd: begin
                if (w_tick) begin
                    // r_shift[1] after the last CMD bit is already ADDR bit 0
                    w_timer_d = BIT_RELOAD;
                    w_shift_d = r_shift >> 1;
                    w_tx_d    = r_shift[1];
                    if (r_cnt == CMD_LAST) begin
                        w_state_d = StAddr;
                        w_cnt_d   = 4'd0;
                    end else begin
                        w_cnt_d = r_cnt + 4'd1;
                    end
                end
            end
            StAddr: begin
                if (w_tick) begin
                    w_timer_d = BIT_RELOAD;
                    if (r_cnt == ADDR_LAST) begin
                        w_state_d = StEof;
                        w_tx_d    = EOF_LVL;
                        w_cnt_d   = 4'd0;
                    end else begin
                        w_shift_d = r_shift >> 1;
                        w_tx_d    = r_shift[1];
                        w_cnt_d   = r_cnt + 4'd1;
                    end
                end
            end
            StEof: begin
                if (w_tick) begin
                    w_timer_d = BIT_RELOAD;
                    if (r_cnt == EOF_LAST) begin
                        w_state_d = StGap;
                        w_tx_d    = IDLE_LVL;
                        w_done_d  = 1'b1;
                        w_cnt_d   = 4'd0;
                    end else begin
                        w_cnt_d = r_cnt + 4'd1;
                    end
                end
            end
            StGap: begin
                if (w_tick) begin
                    if (r_cnt == GAP_LAST) begin
                        w_state_d = StIdle;
                        w_cnt_d   = 4'd0;
                        w_launch  = !w_empty;
                    end else begin
                        w_timer_d = BIT_RELOAD;
                        w_cnt_d   = r_cnt + 4'd1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_launch) begin
            w_state_d = StStart;
            w_tx_d    = START_LVL;
            w_timer_d = BIT_RELOAD;
            w_cnt_d   = 4'd0;
            w_shift_d = frame_order(w_head);
        end
    end

endmodule
